// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-segment front end: unstuffs 0xFF00, halts on markers, and serves a
// left-aligned 32-bit peek window with a variable-length consume port.
module jpeg_bitstream_reader #(
   parameter int BUF_W = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [31:0] peek,
   output logic [5:0]  avail,
   input  logic [5:0]  take_len,
   input  logic        align,
   output logic        marker_valid,
   output logic [7:0]  marker_code,
   input  logic        marker_ack,
   output logic        take_err
);

   localparam int CW = $clog2(BUF_W) + 1;

   typedef enum logic [1:0] {NORMAL, GOT_FF, MARKER} pstate_t;

   pstate_t          state;
   logic [31:0]      word_q;
   logic             word_full;
   logic [1:0]       byte_idx;
   logic [BUF_W-1:0] buf_q, buf_n, buf_take, buf_algn;
   logic [CW-1:0]    cnt_q, cnt_n, cnt_take, cnt_algn;
   logic [CW-1:0]    take_req, avail_ext, t_amt, drop;
   logic [7:0]       cur_byte, app_byte;
   logic             take_over, parse_en, do_append, last_byte, ack_fire;

   always_comb begin
      case (byte_idx)
         2'd0:    cur_byte = word_q[31:24];
         2'd1:    cur_byte = word_q[23:16];
         2'd2:    cur_byte = word_q[15:8];
         default: cur_byte = word_q[7:0];
      endcase

      take_req  = CW'(take_len);
      avail_ext = CW'(avail);
      take_over = take_req > avail_ext;
      t_amt     = take_over ? avail_ext : take_req;
      cnt_take  = cnt_q - t_amt;
      buf_take  = buf_q << t_amt;

      // Bytes are only ever appended whole, so the partial byte sits at the front.
      drop      = align ? CW'(cnt_take[2:0]) : '0;
      cnt_algn  = cnt_take - drop;
      buf_algn  = buf_take << drop;

      parse_en  = word_full && (state != MARKER) && (cnt_take <= CW'(BUF_W - 8));
      do_append = parse_en && (((state == NORMAL) && (cur_byte != 8'hFF)) ||
                               ((state == GOT_FF) && (cur_byte == 8'h00)));
      app_byte  = (state == GOT_FF) ? 8'hFF : cur_byte;
      ack_fire  = marker_ack && (state == MARKER);

      if (ack_fire) begin
         buf_n = '0;
         cnt_n = '0;
      end else if (do_append) begin
         // Buffer bits past count are always zero, so OR-in is a clean insert.
         buf_n = buf_algn | ({app_byte, {(BUF_W-8){1'b0}}} >> cnt_algn);
         cnt_n = cnt_algn + CW'(8);
      end else begin
         buf_n = buf_algn;
         cnt_n = cnt_algn;
      end

      last_byte = parse_en && (byte_idx == 2'd3);
      in_ready  = !word_full || last_byte;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= NORMAL;
         word_q       <= '0;
         word_full    <= 1'b0;
         byte_idx     <= '0;
         buf_q        <= '0;
         cnt_q        <= '0;
         peek         <= '0;
         avail        <= '0;
         marker_valid <= 1'b0;
         marker_code  <= '0;
         take_err     <= 1'b0;
      end else begin
         buf_q <= buf_n;
         cnt_q <= cnt_n;
         peek  <= buf_n[BUF_W-1 -: 32];
         avail <= (cnt_n >= CW'(32)) ? 6'd32 : cnt_n[5:0];
         if (take_over) take_err <= 1'b1;

         if (in_valid && in_ready) begin
            word_q    <= in_data;
            word_full <= 1'b1;
            byte_idx  <= '0;
         end else if (last_byte) begin
            word_full <= 1'b0;
         end else if (parse_en) begin
            byte_idx  <= byte_idx + 2'd1;
         end

         case (state)
            NORMAL: begin
               if (parse_en && cur_byte == 8'hFF) state <= GOT_FF;
            end
            GOT_FF: begin
               // 0xFF after 0xFF is fill: stay put and wait for the real code.
               if (parse_en && cur_byte == 8'h00) begin
                  state <= NORMAL;
               end else if (parse_en && cur_byte != 8'hFF) begin
                  state        <= MARKER;
                  marker_code  <= cur_byte;
                  marker_valid <= 1'b1;
               end
            end
            MARKER: begin
               if (marker_ack) begin
                  state        <= NORMAL;
                  marker_valid <= 1'b0;
               end
            end
            default: state <= NORMAL;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// Directed bench for jpeg_bitstream_reader: stuffing, markers, consume/align, backpressure, reset.
module tb_jpeg_bitstream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] peek;
   logic [5:0]  avail;
   logic [5:0]  take_len;
   logic        align;
   logic        marker_valid;
   logic [7:0]  marker_code;
   logic        marker_ack;
   logic        take_err;

   int checks = 0;
   int errors = 0;

   jpeg_bitstream_reader #(.BUF_W(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .peek(peek), .avail(avail), .take_len(take_len), .align(align),
      .marker_valid(marker_valid), .marker_code(marker_code), .marker_ack(marker_ack),
      .take_err(take_err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Offers a word and returns one cycle after it is accepted.
   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = w;
      #1;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("send_timeout", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic take(input logic [5:0] n);
      take_len = n;
      tick();
      take_len = 6'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; take_len = '0; align = 1'b0; marker_ack = 1'b0;
      tick(2);
      rst = 1'b0;
      tick();
      chk("rst_peek", peek, 32'h0);
      chk("rst_avail", {26'd0, avail}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_marker_valid", {31'd0, marker_valid}, 32'd0);
      chk("rst_take_err", {31'd0, take_err}, 32'd0);

      // Plain word: byte 0 visible at t+2, whole word at t+5.
      send(32'h12345678);
      tick();
      chk("plain_t2_avail", {26'd0, avail}, 32'd8);
      chk("plain_t2_peek", peek, 32'h12000000);
      tick(3);
      chk("plain_avail", {26'd0, avail}, 32'd32);
      chk("plain_peek", peek, 32'h12345678);
      chk("plain_in_ready", {31'd0, in_ready}, 32'd1);
      take(6'd32);
      chk("plain_drain", {26'd0, avail}, 32'd0);

      // Stuffing within a word.
      send(32'hABFF00CD);
      tick(4);
      chk("stuff_avail", {26'd0, avail}, 32'd24);
      chk("stuff_peek", peek, 32'hABFFCD00);
      take(6'd24);

      // Stuffing across a word boundary: 11 11 11 FF 22 22 22 buffered.
      send(32'h111111FF);
      send(32'h00222222);
      tick(5);
      chk("xword_avail", {26'd0, avail}, 32'd32);
      chk("xword_peek", peek, 32'h111111FF);
      take(6'd24);
      chk("xword_peek2", peek, 32'hFF222222);
      take(6'd32);
      chk("xword_drain", {26'd0, avail}, 32'd0);

      // Consume and align.
      send(32'h12345678);
      tick(4);
      chk("ca_peek0", peek, 32'h12345678);
      take(6'd3);
      chk("ca_take3_peek", peek, 32'h91A2B3C0);
      chk("ca_take3_avail", {26'd0, avail}, 32'd29);
      align = 1'b1;
      tick();
      align = 1'b0;
      chk("ca_align_avail", {26'd0, avail}, 32'd24);
      chk("ca_align_peek", peek, 32'h34567800);
      chk("ca_pre_err", {31'd0, take_err}, 32'd0);
      take(6'd30);
      chk("ca_take_err", {31'd0, take_err}, 32'd1);
      chk("ca_over_avail", {26'd0, avail}, 32'd0);

      // Marker mid-word; trailing byte held until ack.
      send(32'h11FFD922);
      tick(3);
      chk("mk_valid", {31'd0, marker_valid}, 32'd1);
      chk("mk_code", {24'd0, marker_code}, 32'hD9);
      chk("mk_avail", {26'd0, avail}, 32'd8);
      chk("mk_peek", peek, 32'h11000000);
      chk("mk_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("mk_hold", {31'd0, marker_valid}, 32'd1);
      marker_ack = 1'b1;
      tick();
      marker_ack = 1'b0;
      chk("mk_ack_valid", {31'd0, marker_valid}, 32'd0);
      chk("mk_ack_avail", {26'd0, avail}, 32'd0);
      chk("mk_ack_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("mk_resume_avail", {26'd0, avail}, 32'd8);
      chk("mk_resume_peek", peek, 32'h22000000);
      take(6'd8);

      // Fill bytes before the marker code.
      send(32'hFFFFFFD8);
      tick(4);
      chk("fill_valid", {31'd0, marker_valid}, 32'd1);
      chk("fill_code", {24'd0, marker_code}, 32'hD8);
      chk("fill_avail", {26'd0, avail}, 32'd0);
      marker_ack = 1'b1;
      tick();
      marker_ack = 1'b0;
      chk("fill_ack_valid", {31'd0, marker_valid}, 32'd0);

      // Backpressure: 64 bits buffered, third word pending.
      send(32'hA0A1A2A3);
      send(32'hB0B1B2B3);
      send(32'hC0C1C2C3);
      tick(2);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_avail", {26'd0, avail}, 32'd32);
      chk("bp_peek", peek, 32'hA0A1A2A3);
      take(6'd8);
      chk("bp_take8_peek", peek, 32'hA1A2A3B0);
      tick();
      take(6'd32);
      chk("bp_resume_peek", peek, 32'hB1B2B3C0);
      take_len = 6'd32;
      tick(6);
      take_len = 6'd0;
      chk("bp_drained", {26'd0, avail}, 32'd0);

      // Reset while in MARKER.
      send(32'h00FFDA00);
      tick(3);
      chk("rm_valid", {31'd0, marker_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rm_peek", peek, 32'h0);
      chk("rm_avail", {26'd0, avail}, 32'd0);
      chk("rm_marker_valid", {31'd0, marker_valid}, 32'd0);
      chk("rm_marker_code", {24'd0, marker_code}, 32'd0);
      chk("rm_take_err", {31'd0, take_err}, 32'd0);
      chk("rm_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;
      tick();
      send(32'h5A5A5A5A);
      tick(4);
      chk("post_rst_peek", peek, 32'h5A5A5A5A);
      chk("post_rst_avail", {26'd0, avail}, 32'd32);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
